test_sequencer: RTL and testbench
=================================

# test_sequencer

Synthesizable hardware self-test sequencer for the MIPS core. It drives a reset pulse into the processor under test, watches the core's data-memory write port for one expected (address, data) pair per test, and scores pass/fail over a fixed cycle window. It repeats this for NUM_TESTS programs and accumulates results. It sits beside `top` in on-chip or FPGA bring-up builds. Expected values come from an external per-test ROM indexed by `test_idx`.

## Interface
- NUM_TESTS, 8, number of tests sequenced per run (>=1)
- AW, 32, address width of `dataadr`/`exp_adr`
- DW, 32, data width of `writedata`/`exp_data`
- RESET_CYCLES, 2, cycles `dut_reset` is held high before each test (>=1)
- WINDOW, 100, cycles the core runs per test (>=1)
- EARLY_EXIT, 0, 1 = end a test on the cycle its match is seen
- STOP_ON_FAIL, 0, 1 = end the run after the first failing test
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low forces all state to reset values immediately
- start  in  1  begin a run; sampled in IDLE or DONE, ignored while busy
- dut_reset  out  1  active-high reset to the core under test
- test_idx  out  IW=max(1,$clog2(NUM_TESTS))  current test number, ROM address
- exp_adr  in  AW  expected write address for `test_idx`, stable while `test_idx` stable
- exp_data  in  DW  expected write data for `test_idx`
- memwrite  in  1  core store strobe
- dataadr  in  AW  core store address
- writedata  in  DW  core store data
- busy  out  1  run in progress
- done  out  1  run finished, held until next start or reset
- pass_mask  out  NUM_TESTS  bit i = test i passed
- pass_count  out  CW=$clog2(NUM_TESTS+1)  number of passing tests
- mismatch_count  out  16  non-matching stores seen in RUN, saturates at 16'hFFFF
- bad_valid  out  1  first mismatching store captured
- bad_adr / bad_data  out  AW / DW  address/data of first mismatching store

## Operation
- States: IDLE, RESET, RUN, SCORE, DONE. Reset values: state IDLE, `dut_reset`=1, `test_idx`=0, `busy`=0, `done`=0, all counts, mask, `bad_*` = 0.
- IDLE: `dut_reset`=1. `start`=1 -> RESET. Clears `pass_mask`, `pass_count`, `mismatch_count`, `bad_*`, `test_idx`, `done`. Sets `busy`.
- RESET: `dut_reset`=1 for exactly RESET_CYCLES cycles, then RUN with timer cleared. Stores seen here are ignored.
- RUN: `dut_reset`=0. Each cycle with `memwrite`=1:
  - match (`dataadr`==`exp_adr` and `writedata`==`exp_data`) sets a per-test `hit` flag.
  - otherwise `mismatch_count`++ (saturating); if `bad_valid`=0, capture `bad_adr`/`bad_data` and set `bad_valid`.
- RUN exit: -> SCORE after WINDOW cycles in RUN, or on the match cycle if EARLY_EXIT=1. A match on the last window cycle counts.
- SCORE (1 cycle, `dut_reset`=1): `pass_mask[test_idx]`<=`hit`, `pass_count`+=`hit`, clear `hit`.
  - If `test_idx`==NUM_TESTS-1, or (STOP_ON_FAIL and !`hit`): -> DONE.
  - Else `test_idx`++ and -> RESET.
- DONE: `busy`=0, `done`=1, `dut_reset`=1, `test_idx` holds last test scored. `start` -> behaves as from IDLE.
- Multiple matches in one test count once. Matching stores are never counted as mismatches.

## Timing
- `start` sampled at edge E: `busy`=1 and `dut_reset`=1 after E; `dut_reset` falls after edge E+RESET_CYCLES.
- Full test length without early exit: RESET_CYCLES+WINDOW+1 cycles. All-tests run: `done` rises after edge E+NUM_TESTS*(RESET_CYCLES+WINDOW+1).
- EARLY_EXIT: match sampled at edge M -> SCORE at M, next test's RESET begins at M+1.
- Store inputs are sampled on rising edge only; `exp_*` must be valid from the edge `test_idx` changes.
- Asynchronous reset low mid-run: `dut_reset`=1 and all outputs at reset values without waiting for a clock. Release is synchronous to next edge.

## Test plan
- NUM_TESTS=2, RESET_CYCLES=2, WINDOW=8. Matching store in RUN cycle 3 of each test -> `pass_mask`=2'b11, `pass_count`=2, `done` rises 22 cycles after start, `mismatch_count`=0.
- Test0 stores 7 to 0x54 while expecting 21 at 0x12; test1 matches -> `pass_mask`=2'b10, `pass_count`=1, `mismatch_count`=1, `bad_valid`=1, `bad_adr`=0x54, `bad_data`=7.
- EARLY_EXIT=1, match in RUN cycle 0 of both tests -> each test 4 cycles, `done` 8 cycles after start, `pass_count`=2.
- STOP_ON_FAIL=1, no stores in test0 -> `done` after 11 cycles, `pass_count`=0, `test_idx`=0, test1 never run (`dut_reset` stays 1).
- Matching store during RESET phase only -> ignored, test fails. Matching store in RUN cycle 7 (last) -> pass.
- Drive `reset` low in RUN cycle 4 -> immediately `dut_reset`=1, `busy`=0, counts 0. After release plus `start`, the run restarts from test 0 and passes normally.

Source files
------------

// File: rtl/test_sequencer_if.sv
// Bus bundle between the self-test sequencer and its environment: the core's
// data-memory store port plus the expected-value ROM lookup.
//
// Transfer semantics: there is no back-pressure on this bundle. A store is
// transferred on every rising clock edge where memwrite is 1; dataadr and
// writedata are qualified by memwrite on that same edge. No ready signal
// exists because the sequencer accepts every store. exp_adr/exp_data are a
// combinational ROM lookup of test_idx and must be valid from the edge on which
// test_idx changes.
interface test_sequencer_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int IW = 3
);
  logic          memwrite;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;
  logic [AW-1:0] exp_adr;
  logic [DW-1:0] exp_data;
  logic [IW-1:0] test_idx;

  // Sequencer side: observes stores and ROM data, drives the ROM index.
  modport master (
    output test_idx,
    input  memwrite, dataadr, writedata, exp_adr, exp_data
  );

  // Environment side: the core's store port and the per-test ROM.
  modport slave (
    input  test_idx,
    output memwrite, dataadr, writedata, exp_adr, exp_data
  );
endinterface

// File: rtl/test_sequencer.sv
// Hardware self-test sequencer for the MIPS core. For each of NUM_TESTS
// programs it holds the core in reset, lets it run for a fixed window while
// watching its store port for one expected (address, data) pair, then scores
// the test. Results accumulate in pass_mask/pass_count; the first wrong store
// of the run is captured for debug.
module test_sequencer #(
  parameter int NUM_TESTS    = 8,
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int RESET_CYCLES = 2,
  parameter int WINDOW       = 100,
  parameter int EARLY_EXIT   = 0,
  parameter int STOP_ON_FAIL = 0,
  localparam int IW  = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
  localparam int CW  = $clog2(NUM_TESTS + 1),
  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1,
  localparam int TW  = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  test_sequencer_if.master     bus,
  output logic                 dut_reset,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_TESTS-1:0] pass_mask,
  output logic [CW-1:0]        pass_count,
  output logic [15:0]          mismatch_count,
  output logic                 bad_valid,
  output logic [AW-1:0]        bad_adr,
  output logic [DW-1:0]        bad_data,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_SCORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [RCW-1:0] RC_LAST  = RCW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0]  T_LAST   = TW'(WINDOW - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(NUM_TESTS - 1);

  state_t               state_q, state_d;
  logic [RCW-1:0]       rcnt_q, rcnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 hit_q, hit_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NUM_TESTS-1:0] mask_q, mask_d;
  logic [CW-1:0]        pcount_q, pcount_d;
  logic [15:0]          mm_q, mm_d;
  logic                 bad_valid_q, bad_valid_d;
  logic [AW-1:0]        bad_adr_q, bad_adr_d;
  logic [DW-1:0]        bad_data_q, bad_data_d;

  logic store_match;

  // A store matches only when both address and data equal the expected pair.
  assign store_match = bus.memwrite &&
                       (bus.dataadr == bus.exp_adr) &&
                       (bus.writedata == bus.exp_data);

  // State and result registers; reset drops everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rcnt_q      <= '0;
      timer_q     <= '0;
      hit_q       <= 1'b0;
      idx_q       <= '0;
      mask_q      <= '0;
      pcount_q    <= '0;
      mm_q        <= '0;
      bad_valid_q <= 1'b0;
      bad_adr_q   <= '0;
      bad_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      timer_q     <= timer_d;
      hit_q       <= hit_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      pcount_q    <= pcount_d;
      mm_q        <= mm_d;
      bad_valid_q <= bad_valid_d;
      bad_adr_q   <= bad_adr_d;
      bad_data_q  <= bad_data_d;
    end
  end

  // Next-state logic: sequence reset/run/score per test and track results.
  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    timer_d     = timer_q;
    hit_d       = hit_q;
    idx_d       = idx_q;
    mask_d      = mask_q;
    pcount_d    = pcount_q;
    mm_d        = mm_q;
    bad_valid_d = bad_valid_q;
    bad_adr_d   = bad_adr_q;
    bad_data_d  = bad_data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // A new run wipes all results from the previous one.
        if (start) begin
          state_d     = S_RESET;
          rcnt_d      = '0;
          timer_d     = '0;
          hit_d       = 1'b0;
          idx_d       = '0;
          mask_d      = '0;
          pcount_d    = '0;
          mm_d        = '0;
          bad_valid_d = 1'b0;
          bad_adr_d   = '0;
          bad_data_d  = '0;
        end
      end

      S_RESET: begin
        // Stores during the core's reset are meaningless and ignored.
        if (rcnt_q == RC_LAST) begin
          state_d = S_RUN;
          timer_d = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end

      S_RUN: begin
        if (bus.memwrite) begin
          if (store_match) begin
            hit_d = 1'b1;
          end else begin
            if (mm_q != 16'hFFFF) begin
              mm_d = mm_q + 16'd1;
            end
            if (!bad_valid_q) begin
              bad_valid_d = 1'b1;
              bad_adr_d   = bus.dataadr;
              bad_data_d  = bus.writedata;
            end
          end
        end
        // A match on the final window cycle still lands in hit before scoring.
        if (((EARLY_EXIT != 0) && store_match) || (timer_q == T_LAST)) begin
          state_d = S_SCORE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_SCORE: begin
        mask_d[idx_q] = hit_q;
        pcount_d      = pcount_q + CW'(hit_q);
        hit_d         = 1'b0;
        if ((idx_q == IDX_LAST) || ((STOP_ON_FAIL != 0) && !hit_q)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          rcnt_d  = '0;
          state_d = S_RESET;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Core reset is released only while a test program is running.
  assign dut_reset      = (state_q != S_RUN);
  assign busy           = (state_q == S_RESET) || (state_q == S_RUN) ||
                          (state_q == S_SCORE);
  assign done           = (state_q == S_DONE);
  assign bus.test_idx   = idx_q;
  assign pass_mask      = mask_q;
  assign pass_count     = pcount_q;
  assign mismatch_count = mm_q;
  assign bad_valid      = bad_valid_q;
  assign bad_adr        = bad_adr_q;
  assign bad_data       = bad_data_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: three instances (plain, early-exit, stop-on-fail)
// with NUM_TESTS=2, RESET_CYCLES=2, WINDOW=8, driven from a table of runs,
// plus a hand-written asynchronous reset sequence.
module tb_test_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        start;
  int          sel;
  logic        memwrite;
  logic [31:0] dataadr, writedata;
  logic [31:0] rom_adr [2];
  logic [31:0] rom_data[2];

  test_sequencer_if #(.AW(32), .DW(32), .IW(1)) if_a ();
  test_sequencer_if #(.AW(32), .DW(32), .IW(1)) if_e ();
  test_sequencer_if #(.AW(32), .DW(32), .IW(1)) if_s ();

  assign if_a.memwrite = memwrite;  assign if_e.memwrite = memwrite;  assign if_s.memwrite = memwrite;
  assign if_a.dataadr = dataadr;    assign if_e.dataadr = dataadr;    assign if_s.dataadr = dataadr;
  assign if_a.writedata = writedata; assign if_e.writedata = writedata; assign if_s.writedata = writedata;
  assign if_a.exp_adr  = rom_adr[if_a.test_idx];  assign if_a.exp_data = rom_data[if_a.test_idx];
  assign if_e.exp_adr  = rom_adr[if_e.test_idx];  assign if_e.exp_data = rom_data[if_e.test_idx];
  assign if_s.exp_adr  = rom_adr[if_s.test_idx];  assign if_s.exp_data = rom_data[if_s.test_idx];

  // ---------------- DUT outputs ----------------
  logic        dr[3], bz[3], dn[3], bv[3], tix[3];
  logic [1:0]  pm[3], pc[3];
  logic [15:0] mc[3];
  logic [31:0] ba[3], bd[3];
  logic [2:0]  st[3];

  assign tix[0] = if_a.test_idx;
  assign tix[1] = if_e.test_idx;
  assign tix[2] = if_s.test_idx;

  test_sequencer #(.NUM_TESTS(2), .AW(32), .DW(32), .RESET_CYCLES(2), .WINDOW(8),
                   .EARLY_EXIT(0), .STOP_ON_FAIL(0)) dut_a (
    .clk(clk), .reset(reset), .start(start && (sel == 0)), .bus(if_a.master),
    .dut_reset(dr[0]), .busy(bz[0]), .done(dn[0]), .pass_mask(pm[0]), .pass_count(pc[0]),
    .mismatch_count(mc[0]), .bad_valid(bv[0]), .bad_adr(ba[0]), .bad_data(bd[0]),
    .dbg_state(st[0]));

  test_sequencer #(.NUM_TESTS(2), .AW(32), .DW(32), .RESET_CYCLES(2), .WINDOW(8),
                   .EARLY_EXIT(1), .STOP_ON_FAIL(0)) dut_e (
    .clk(clk), .reset(reset), .start(start && (sel == 1)), .bus(if_e.master),
    .dut_reset(dr[1]), .busy(bz[1]), .done(dn[1]), .pass_mask(pm[1]), .pass_count(pc[1]),
    .mismatch_count(mc[1]), .bad_valid(bv[1]), .bad_adr(ba[1]), .bad_data(bd[1]),
    .dbg_state(st[1]));

  test_sequencer #(.NUM_TESTS(2), .AW(32), .DW(32), .RESET_CYCLES(2), .WINDOW(8),
                   .EARLY_EXIT(0), .STOP_ON_FAIL(1)) dut_s (
    .clk(clk), .reset(reset), .start(start && (sel == 2)), .bus(if_s.master),
    .dut_reset(dr[2]), .busy(bz[2]), .done(dn[2]), .pass_mask(pm[2]), .pass_count(pc[2]),
    .mismatch_count(mc[2]), .bad_valid(bv[2]), .bad_adr(ba[2]), .bad_data(bd[2]),
    .dbg_state(st[2]));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One run: stores are placed at edge offset k after the start edge E (k=0).
  // Test0 RUN cycle c is k=3+c; test1 RUN cycle c is k=14+c (no early exit).
  typedef struct {
    int          sel;
    int          k0;  logic [31:0] a0, d0;
    int          k1;  logic [31:0] a1, d1;
    logic [31:0] ra0, rd0, ra1, rd1;
    int          cyc;
    logic [1:0]  mask;
    logic [1:0]  cnt;
    logic [15:0] mm;
    logic        bvld;
    logic [31:0] badr, bdat;
    logic        idx;
    int          low;
  } vec_t;

  vec_t vecs[7];

  // ---------------- driver ----------------
  task automatic run_vector(input int v);
    vec_t t;
    int done_k;
    int low;
    t = vecs[v];
    sel = t.sel;
    rom_adr[0] = t.ra0; rom_data[0] = t.rd0;
    rom_adr[1] = t.ra1; rom_data[1] = t.rd1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check($sformatf("v%0d busy_after_start", v), 32'(bz[sel]), 32'd1);
    check($sformatf("v%0d dut_reset_after_start", v), 32'(dr[sel]), 32'd1);
    done_k = -1;
    low = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == t.k0) begin
        memwrite = 1'b1; dataadr = t.a0; writedata = t.d0;
      end else if (k == t.k1) begin
        memwrite = 1'b1; dataadr = t.a1; writedata = t.d1;
      end else begin
        memwrite = 1'b0; dataadr = $urandom; writedata = $urandom;
      end
      @(posedge clk);
      #1;
      if (!dr[sel]) low++;
      if (dn[sel]) begin
        done_k = k;
        break;
      end
    end
    @(negedge clk);
    memwrite = 1'b0;
    check($sformatf("v%0d done_cycle", v), 32'(done_k), 32'(t.cyc));
    check($sformatf("v%0d run_cycles", v), 32'(low), 32'(t.low));
    check($sformatf("v%0d pass_mask", v), 32'(pm[sel]), 32'(t.mask));
    check($sformatf("v%0d pass_count", v), 32'(pc[sel]), 32'(t.cnt));
    check($sformatf("v%0d mismatch_count", v), 32'(mc[sel]), 32'(t.mm));
    check($sformatf("v%0d bad_valid", v), 32'(bv[sel]), 32'(t.bvld));
    check($sformatf("v%0d bad_adr", v), ba[sel], t.badr);
    check($sformatf("v%0d bad_data", v), bd[sel], t.bdat);
    check($sformatf("v%0d test_idx", v), 32'(tix[sel]), 32'(t.idx));
    check($sformatf("v%0d busy_end", v), 32'(bz[sel]), 32'd0);
    check($sformatf("v%0d dut_reset_end", v), 32'(dr[sel]), 32'd1);
  endtask

  // ---------------- main ----------------
  initial begin
    //            sel k0  a0        d0         k1  a1        d1         ra0       rd0        ra1       rd1        cyc mask   cnt   mm  bv    badr   bdat  idx   low
    vecs[0] = '{0,  6, 32'h100, 32'hAAAA, 17, 32'h104, 32'h5555, 32'h100, 32'hAAAA, 32'h104, 32'h5555, 22, 2'b11, 2'd2, 16'd0, 1'b0, 32'h0,  32'd0, 1'b1, 16};
    vecs[1] = '{0,  6, 32'h54,  32'd7,    17, 32'h104, 32'h5555, 32'h12,  32'd21,    32'h104, 32'h5555, 22, 2'b10, 2'd1, 16'd1, 1'b1, 32'h54, 32'd7, 1'b1, 16};
    vecs[2] = '{1,  3, 32'h200, 32'h11,    7, 32'h204, 32'h22,   32'h200, 32'h11,    32'h204, 32'h22,    8, 2'b11, 2'd2, 16'd0, 1'b0, 32'h0,  32'd0, 1'b1,  2};
    vecs[3] = '{2, -1, 32'h0,   32'h0,    -1, 32'h0,   32'h0,    32'h300, 32'h33,    32'h304, 32'h44,   11, 2'b00, 2'd0, 16'd0, 1'b0, 32'h0,  32'd0, 1'b0,  8};
    vecs[4] = '{0,  1, 32'h100, 32'hAAAA, 21, 32'h104, 32'h5555, 32'h100, 32'hAAAA, 32'h104, 32'h5555, 22, 2'b10, 2'd1, 16'd0, 1'b0, 32'h0,  32'd0, 1'b1, 16};
    vecs[5] = '{0, 10, 32'h100, 32'hAAAA, 12, 32'h104, 32'h5555, 32'h100, 32'hAAAA, 32'h104, 32'h5555, 22, 2'b01, 2'd1, 16'd0, 1'b0, 32'h0,  32'd0, 1'b1, 16};
    vecs[6] = '{2,  6, 32'h100, 32'hAAAA, 15, 32'h8,   32'h9,    32'h100, 32'hAAAA, 32'h104, 32'h5555, 22, 2'b01, 2'd1, 16'd1, 1'b1, 32'h8,  32'h9, 1'b1, 16};

    reset = 1'b0; start = 1'b0; sel = 0;
    memwrite = 1'b0; dataadr = '0; writedata = '0;
    rom_adr[0] = '0; rom_data[0] = '0; rom_adr[1] = '0; rom_data[1] = '0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst%0d dut_reset", d), 32'(dr[d]), 32'd1);
      check($sformatf("rst%0d busy", d), 32'(bz[d]), 32'd0);
      check($sformatf("rst%0d done", d), 32'(dn[d]), 32'd0);
      check($sformatf("rst%0d test_idx", d), 32'(tix[d]), 32'd0);
      check($sformatf("rst%0d pass_mask", d), 32'(pm[d]), 32'd0);
      check($sformatf("rst%0d pass_count", d), 32'(pc[d]), 32'd0);
      check($sformatf("rst%0d mismatch_count", d), 32'(mc[d]), 32'd0);
      check($sformatf("rst%0d bad_valid", d), 32'(bv[d]), 32'd0);
      check($sformatf("rst%0d state", d), 32'(st[d]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 7; v++) run_vector(v);

    // Asynchronous reset in RUN cycle 4 of test0, after a wrong store was seen.
    sel = 0;
    rom_adr[0] = 32'h100; rom_data[0] = 32'hAAAA;
    rom_adr[1] = 32'h104; rom_data[1] = 32'h5555;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      memwrite  = (k == 5);
      dataadr   = 32'h8;
      writedata = 32'h9;
      @(posedge clk);
    end
    #1;
    memwrite = 1'b0;
    check("arst pre dut_reset", 32'(dr[0]), 32'd0);
    check("arst pre mismatch_count", 32'(mc[0]), 32'd1);
    check("arst pre bad_valid", 32'(bv[0]), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst dut_reset", 32'(dr[0]), 32'd1);
    check("arst busy", 32'(bz[0]), 32'd0);
    check("arst done", 32'(dn[0]), 32'd0);
    check("arst mismatch_count", 32'(mc[0]), 32'd0);
    check("arst bad_valid", 32'(bv[0]), 32'd0);
    check("arst bad_adr", ba[0], 32'h0);
    check("arst pass_count", 32'(pc[0]), 32'd0);
    check("arst test_idx", 32'(tix[0]), 32'd0);
    check("arst state", 32'(st[0]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_vector(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
